// File: rtl/imm_extend_buffer_if.sv
// Handshake bundle for the immediate-extension buffer: producer side pushes raw
// immediates, consumer side drains extended results.
interface imm_extend_buffer_if #(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] Imm;
  logic [1:0]          mode;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_neg;
  logic [1:0]          count;

  modport master (
    output in_valid, Imm, mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg, count
  );

  modport slave (
    input  in_valid, Imm, mode, out_ready,
    output in_ready, out_valid, out_data, out_neg, count
  );
endinterface

// File: rtl/imm_extend_buffer.sv
// Immediate extender (sign / zero / upper / branch-offset) feeding a 2-entry
// valid/ready FIFO that sits ahead of the ALU-B operand mux.
module imm_extend_buffer #(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32,
  parameter int BR_SHIFT = 2
) (
  input logic               clk,
  input logic               reset,
  input logic               flush,
  imm_extend_buffer_if.slave bus
);
  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] sext_value;
  logic [WIDTH-1:0] ext_value;
  logic             push;
  logic             pop;

  // Entries are stored already extended so the read side is a plain mux.
  always_comb begin
    sext_value = WIDTH'($signed(bus.Imm));
    ext_value  = sext_value;
    case (bus.mode)
      2'b00:   ext_value = sext_value;
      2'b01:   ext_value = WIDTH'(bus.Imm);
      2'b10:   ext_value = WIDTH'(bus.Imm) << (WIDTH - IN_WIDTH);
      2'b11:   ext_value = sext_value << BR_SHIFT;
      default: ext_value = sext_value;
    endcase
  end

  assign bus.in_ready  = !reset && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem[head] : '0;
  assign bus.out_neg   = bus.out_data[WIDTH-1];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Flush outranks push/pop so a same-cycle push is dropped with the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= ext_value;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_imm_extend_buffer.sv
// Randomized and directed check of imm_extend_buffer against a queue-based
// model that applies the extension rules with plain integer arithmetic.
module tb_imm_extend_buffer;
  logic clk;
  logic reset;
  logic flush;

  imm_extend_buffer_if #(.IN_WIDTH(16), .WIDTH(32)) bus ();

  imm_extend_buffer #(.IN_WIDTH(16), .WIDTH(32), .BR_SHIFT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_q[$];
  bit          model_rst;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] refExt(input logic [15:0] imm, input logic [1:0] m);
    longint u = longint'(imm);
    longint s = imm[15] ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic checkState();
    logic [31:0] head_val;
    head_val = (model_q.size() != 0) ? model_q[0] : 32'd0;
    checkOutput("out_valid", 64'(bus.out_valid), 64'(model_q.size() != 0));
    checkOutput("out_data", 64'(bus.out_data), 64'(head_val));
    checkOutput("out_neg", 64'(bus.out_neg), 64'(head_val[31]));
    checkOutput("count", 64'(bus.count), 64'(model_q.size()));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(!model_rst && model_q.size() != 2));
  endtask

  // One clock of stimulus: check state at the falling edge, drive, update the
  // model for the coming rising edge, then return to idle inputs.
  task automatic applyStimulus(input bit f, input bit v, input logic [15:0] imm,
                               input logic [1:0] m, input bit r);
    bit m_ready;
    bit m_pop;
    @(negedge clk);
    checkState();
    flush         = f;
    bus.in_valid  = v;
    bus.Imm       = imm;
    bus.mode      = m;
    bus.out_ready = r;
    m_ready = !model_rst && model_q.size() != 2;
    m_pop   = model_q.size() != 0 && r;
    if (f) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (v && m_ready) model_q.push_back(refExt(imm, m));
    end
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic directedExt(input string tag, input logic [15:0] imm, input logic [1:0] m,
                             input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, imm, m, 1'b0);
    @(negedge clk);
    checkOutput(tag, 64'(bus.out_data), 64'(exp));
    checkOutput({tag, "_neg"}, 64'(bus.out_neg), 64'(exp[31]));
    applyStimulus(1'b0, 1'b0, 16'h0, 2'd0, 1'b1);
  endtask

  initial begin
    reset         = 1'b1;
    model_rst     = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Imm       = '0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b0;
    #3;
    checkState();
    @(negedge clk);
    reset     = 1'b0;
    model_rst = 1'b0;

    directedExt("sext_pos", 16'h0010, 2'd0, 32'h0000_0010);
    directedExt("sext_neg", 16'hFFF0, 2'd0, 32'hFFFF_FFF0);
    directedExt("zext", 16'hFFF0, 2'd1, 32'h0000_FFF0);
    directedExt("upper", 16'h1234, 2'd2, 32'h1234_0000);
    directedExt("branch_neg", 16'hFFFF, 2'd3, 32'hFFFF_FFFC);
    directedExt("branch_pos", 16'h0004, 2'd3, 32'h0000_0010);

    // Backpressure: third push must be held off until a slot frees up.
    applyStimulus(1'b0, 1'b1, 16'd1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'd2, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'd3, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd3, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'(i), 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'hAAAA, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h5555, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h7777, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 1'b0);

    // Asynchronous reset landing between clock edges with one entry held.
    applyStimulus(1'b0, 1'b1, 16'h0055, 2'd0, 1'b0);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    model_rst = 1'b1;
    model_q.delete();
    #1;
    checkState();
    @(negedge clk);
    reset     = 1'b0;
    model_rst = 1'b0;
    directedExt("post_reset", 16'h8000, 2'd0, 32'hFFFF_8000);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(15) == 0, 1'($urandom), 16'($urandom),
                    2'($urandom), 1'($urandom));
    end
    @(negedge clk);
    checkState();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
